// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire reader: FSM states, frame layout
// and the checksum rule applied to a completed 40-bit frame.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    FINISH,
    ERRO
  } dht_state_e;

  localparam int FRAME_BITS     = 40;
  localparam int OFS_HUM_INT    = 32;
  localparam int OFS_HUM_FLOAT  = 24;
  localparam int OFS_TEMP_INT   = 16;
  localparam int OFS_TEMP_FLOAT = 8;
  localparam int OFS_CRC        = 0;

  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] f);
    logic [7:0] soma;
    soma = f[OFS_HUM_INT +: 8] + f[OFS_HUM_FLOAT +: 8]
         + f[OFS_TEMP_INT +: 8] + f[OFS_TEMP_FLOAT +: 8];
    return soma == f[OFS_CRC +: 8];
  endfunction

endpackage

// File: rtl/gerador_tick_us.sv
// Prescaler: one-cycle us_tick every DIV clocks (DIV = clocks per microsecond).
module gerador_tick_us #(
  parameter int DIV = 50
) (
  input  logic clock,
  input  logic reset,
  output logic us_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap    = (cnt_q == CW'(DIV - 1));
  assign us_tick = wrap;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (wrap) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_leitor.sv
// DHT11 reader: host start pulse, response preamble check, 40-bit capture and
// frame publication with checksum status and a sticky timeout flag.
module dht11_leitor
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int START_LOW_US     = 18_000,
  parameter int BIT_THRESHOLD_US = 40,
  parameter int TIMEOUT_US       = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_drive_low,
  output logic [7:0] HUM_INT,
  output logic [7:0] HUM_FLOAT,
  output logic [7:0] TEMP_INT,
  output logic [7:0] TEMP_FLOAT,
  output logic [7:0] CRC,
  output logic       crc_ok,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output dht_state_e estado_o
);

  localparam int PH_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int PW     = $clog2(PH_MAX + 2);

  dht_state_e            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [5:0]            idx_q, idx_d;
  logic [2:0]            sync_q;
  logic                  crc_ok_q, crc_ok_d;
  logic                  done_q, done_d;
  logic                  erro_q, erro_d;
  logic                  us_tick, rise, fall, timeout, bit_val;

  gerador_tick_us #(.DIV(CLK_FREQ_HZ / 1_000_000)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .us_tick (us_tick)
  );

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous level.
  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign timeout = (phase_q >= PW'(TIMEOUT_US));
  // Phase counter starts at 0 on the entry edge, so a W us high phase reads W-1.
  assign bit_val = (phase_q >= PW'(BIT_THRESHOLD_US - 1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    data_d   = data_q;
    crc_ok_d = crc_ok_q;
    done_d   = 1'b0;
    erro_d   = erro_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START_LOW;
        erro_d  = 1'b0;
      end
      START_LOW: if (phase_q >= PW'(START_LOW_US)) state_d = RELEASE;
      RELEASE: begin
        if (timeout)   begin state_d = ERRO; erro_d = 1'b1; end
        else if (fall) state_d = RESP_LOW;
      end
      RESP_LOW: begin
        if (timeout)   begin state_d = ERRO; erro_d = 1'b1; end
        else if (rise) state_d = RESP_HIGH;
      end
      RESP_HIGH: begin
        if (timeout) begin state_d = ERRO; erro_d = 1'b1; end
        else if (fall) begin
          state_d = BIT_LOW;
          idx_d   = '0;
        end
      end
      BIT_LOW: begin
        if (timeout)   begin state_d = ERRO; erro_d = 1'b1; end
        else if (rise) state_d = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (timeout) begin state_d = ERRO; erro_d = 1'b1; end
        else if (fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], bit_val};
          if (idx_q == 6'(FRAME_BITS - 1)) state_d = FINISH;
          else begin
            idx_d   = idx_q + 6'd1;
            state_d = BIT_LOW;
          end
        end
      end
      FINISH: begin
        data_d   = shift_q;
        crc_ok_d = checksum_ok(shift_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      ERRO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    phase_d = phase_q + {{(PW-1){1'b0}}, us_tick};
    if (state_d != state_q) phase_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      sync_q   <= 3'b111;
      crc_ok_q <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      sync_q   <= {sync_q[1:0], dht_in};
      crc_ok_q <= crc_ok_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
    end
  end

  assign dht_drive_low = (state_q == START_LOW);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign erro          = erro_q;
  assign crc_ok        = crc_ok_q;
  assign estado_o      = state_q;
  assign HUM_INT       = data_q[OFS_HUM_INT +: 8];
  assign HUM_FLOAT     = data_q[OFS_HUM_FLOAT +: 8];
  assign TEMP_INT      = data_q[OFS_TEMP_INT +: 8];
  assign TEMP_FLOAT    = data_q[OFS_TEMP_FLOAT +: 8];
  assign CRC           = data_q[OFS_CRC +: 8];

endmodule

// File: tb/tb_dht11_leitor.sv
// Self-checking bench for dht11_leitor: a bus model plays the sensor and a
// scoreboard compares every published frame against the expected queue.
module tb_dht11_leitor;
  import dht11_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dht_in = 1'b1;
  logic       dht_drive_low;
  logic [7:0] HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC;
  logic       crc_ok, busy, done, erro;
  dht_state_e estado_o;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [40:0] exp_q[$];
  logic [40:0] last_exp = '0;
  logic [40:0] m_exp, m_got;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #900_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  dht11_leitor #(
    .CLK_FREQ_HZ      (1_000_000),
    .START_LOW_US     (100),
    .BIT_THRESHOLD_US (40),
    .TIMEOUT_US       (200)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .dht_in        (dht_in),
    .dht_drive_low (dht_drive_low),
    .HUM_INT       (HUM_INT),
    .HUM_FLOAT     (HUM_FLOAT),
    .TEMP_INT      (TEMP_INT),
    .TEMP_FLOAT    (TEMP_FLOAT),
    .CRC           (CRC),
    .crc_ok        (crc_ok),
    .busy          (busy),
    .done          (done),
    .erro          (erro),
    .estado_o      (estado_o)
  );

  // Expected record: {crc_ok, frame}
  function automatic logic [40:0] expect_frame(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return {(s == f[7:0]), f};
  endfunction

  function automatic logic [40:0] observed();
    return {crc_ok, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got frame %h with no expected entry", observed());
      end else begin
        m_exp = exp_q.pop_front();
        m_got = observed();
        last_exp = m_exp;
        if (m_got !== m_exp) begin
          errors++;
          $display("FAIL frame got %h exp %h", m_got, m_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_read(output logic b0, output logic d0, output logic e0, output int low_cyc);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    b0 = busy;
    d0 = dht_drive_low;
    e0 = erro;
    low_cyc = 0;
    while (dht_drive_low === 1'b1 && low_cyc < 1000) begin
      cyc(1);
      low_cyc++;
    end
  endtask

  task automatic drive_frame(input logic [39:0] f, input int hi0, input int hi1,
                             input int n_bits, input int glitch_idx);
    dht_in = 1'b1; cyc(30);
    dht_in = 1'b0; cyc(80);
    dht_in = 1'b1; cyc(80);
    for (int i = 0; i < n_bits; i++) begin
      dht_in = 1'b0;
      if (i == glitch_idx) begin
        cyc(10);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(39);
      end else begin
        cyc(50);
      end
      dht_in = 1'b1;
      cyc(f[39-i] ? hi1 : hi0);
    end
    if (n_bits == 40) begin
      dht_in = 1'b0; cyc(50);
      dht_in = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cyc(5);
    checks += 5;
    if (dht_drive_low !== 1'b0) begin errors++; $display("FAIL reset_drive got %b exp 0", dht_drive_low); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro got %b exp 0", erro); end
    if (observed() !== 41'h0) begin errors++; $display("FAIL reset_data got %h exp 0", observed()); end
    reset = 1'b0;
    cyc(3);
  endtask

  task automatic test_valid_frame();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'h37_00_19_00_50;
    exp_q.push_back(expect_frame(f));
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    checks += 3;
    if (b0 !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", b0); end
    if (d0 !== 1'b1) begin errors++; $display("FAIL start_drive got %b exp 1", d0); end
    if (lc < 99 || lc > 102) begin errors++; $display("FAIL start_low_len got %0d exp 99..102", lc); end
    drive_frame(f, 26, 70, 40, -1);
    cyc(60);
    checks += 8;
    if (done_cnt !== dc + 1) begin errors++; $display("FAIL valid_done_cnt got %0d exp %0d", done_cnt, dc + 1); end
    if (erro !== 1'b0) begin errors++; $display("FAIL valid_erro got %b exp 0", erro); end
    if (HUM_INT !== 8'h37) begin errors++; $display("FAIL valid_hum got %h exp 37", HUM_INT); end
    if (TEMP_INT !== 8'h19) begin errors++; $display("FAIL valid_temp got %h exp 19", TEMP_INT); end
    if (CRC !== 8'h50) begin errors++; $display("FAIL valid_crc got %h exp 50", CRC); end
    if (crc_ok !== 1'b1) begin errors++; $display("FAIL valid_crc_ok got %b exp 1", crc_ok); end
    if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy got %b exp 0", busy); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL valid_queue got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'h37_00_19_00_51;
    exp_q.push_back(expect_frame(f));
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    drive_frame(f, 26, 70, 40, -1);
    cyc(60);
    checks += 3;
    if (done_cnt !== dc + 1) begin errors++; $display("FAIL badcrc_done_cnt got %0d exp %0d", done_cnt, dc + 1); end
    if (crc_ok !== 1'b0) begin errors++; $display("FAIL badcrc_crc_ok got %b exp 0", crc_ok); end
    if (CRC !== 8'h51) begin errors++; $display("FAIL badcrc_crc got %h exp 51", CRC); end
  endtask

  task automatic test_no_sensor();
    logic b0, d0, e0;
    int lc, dc, t;
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    t = 0;
    while (erro !== 1'b1 && t < 400) begin
      cyc(1);
      t++;
    end
    checks++;
    if (t < 198 || t > 203) begin errors++; $display("FAIL nosensor_timeout got %0d exp 198..203", t); end
    cyc(1);
    checks += 4;
    if (erro !== 1'b1) begin errors++; $display("FAIL nosensor_erro got %b exp 1", erro); end
    if (busy !== 1'b0) begin errors++; $display("FAIL nosensor_busy got %b exp 0", busy); end
    if (observed() !== last_exp) begin errors++; $display("FAIL nosensor_data got %h exp %h", observed(), last_exp); end
    if (done_cnt !== dc) begin errors++; $display("FAIL nosensor_done got %0d exp %0d", done_cnt, dc); end
  endtask

  task automatic test_bit_stall();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'hAA_55_AA_55_FF;
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    checks++;
    if (e0 !== 1'b0) begin errors++; $display("FAIL stall_erro_clear got %b exp 0", e0); end
    drive_frame(f, 26, 70, 10, -1);
    dht_in = 1'b0; cyc(50);
    dht_in = 1'b1; cyc(250);
    checks += 4;
    if (erro !== 1'b1) begin errors++; $display("FAIL stall_erro got %b exp 1", erro); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b exp 0", busy); end
    if (observed() !== last_exp) begin errors++; $display("FAIL stall_data got %h exp %h", observed(), last_exp); end
    if (done_cnt !== dc) begin errors++; $display("FAIL stall_done got %0d exp %0d", done_cnt, dc); end
  endtask

  task automatic test_threshold();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'h0F_00_0A_05_1E;
    exp_q.push_back(expect_frame(f));
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    checks++;
    if (e0 !== 1'b0) begin errors++; $display("FAIL thr_erro_clear got %b exp 0", e0); end
    drive_frame(f, 39, 40, 40, -1);
    cyc(60);
    checks += 3;
    if (done_cnt !== dc + 1) begin errors++; $display("FAIL thr_done_cnt got %0d exp %0d", done_cnt, dc + 1); end
    if (HUM_INT !== 8'h0F) begin errors++; $display("FAIL thr_hum got %h exp 0f", HUM_INT); end
    if (crc_ok !== 1'b1) begin errors++; $display("FAIL thr_crc_ok got %b exp 1", crc_ok); end
  endtask

  task automatic test_start_ignored();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'h41_02_1A_03_60;
    exp_q.push_back(expect_frame(f));
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    drive_frame(f, 26, 70, 40, 5);
    cyc(60);
    checks += 3;
    if (done_cnt !== dc + 1) begin errors++; $display("FAIL ignore_done_cnt got %0d exp %0d", done_cnt, dc + 1); end
    if (erro !== 1'b0) begin errors++; $display("FAIL ignore_erro got %b exp 0", erro); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic b0, d0, e0;
    int lc, dc;
    logic [39:0] f;
    f = 40'h12_34_56_78_14;
    dc = done_cnt;
    start_read(b0, d0, e0, lc);
    drive_frame(f, 26, 70, 20, -1);
    reset = 1'b1;
    cyc(1);
    checks += 4;
    if (dht_drive_low !== 1'b0) begin errors++; $display("FAIL midreset_drive got %b exp 0", dht_drive_low); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    if (observed() !== 41'h0) begin errors++; $display("FAIL midreset_data got %h exp 0", observed()); end
    if (done_cnt !== dc) begin errors++; $display("FAIL midreset_done got %0d exp %0d", done_cnt, dc); end
    reset = 1'b0;
    last_exp = '0;
    cyc(5);
  endtask

  task automatic test_back_to_back();
    logic b0, d0, e0;
    int lc, dc;
    logic [7:0] h, hf, t, tf, c;
    logic [39:0] f;
    for (int k = 0; k < 3; k++) begin
      h  = 8'($urandom_range(0, 255));
      hf = 8'($urandom_range(0, 255));
      t  = 8'($urandom_range(0, 255));
      tf = 8'($urandom_range(0, 255));
      c  = h + hf + t + tf + 8'($urandom_range(0, 1));
      f  = {h, hf, t, tf, c};
      exp_q.push_back(expect_frame(f));
      dc = done_cnt;
      start_read(b0, d0, e0, lc);
      checks += 2;
      if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", b0); end
      if (lc < 99 || lc > 102) begin errors++; $display("FAIL b2b_low_len got %0d exp 99..102", lc); end
      drive_frame(f, 26, 70, 40, -1);
      cyc(10);
      checks++;
      if (done_cnt !== dc + 1) begin errors++; $display("FAIL b2b_done_cnt got %0d exp %0d", done_cnt, dc + 1); end
    end
    cyc(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_no_sensor();
    test_bit_stall();
    test_threshold();
    test_start_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
